// File: rtl/gray_conv_pkg.sv
// Shared state type, source-ID width and a Gray-to-binary reference helper
// for the shared bit-serial converter.
package gray_conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int SRC_W = 1;

  // Each binary bit is the XOR of all Gray bits at or above it; narrower words
  // are zero-extended so the upper bits do not disturb the result.
  function automatic logic [31:0] gray_to_bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_conv_sched_arb.sv
// Two-way round-robin arbiter: a lone requester always wins, and on contention
// rr_i picks the winner. Purely combinational; the pointer lives in the parent.
module gray_rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       rr_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = valid_i;
    if (valid_i == 2'b11) begin
      grant_o = rr_i ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/gray_conv_sched.sv
// Bit-serial Gray-to-binary converter shared by two requesters through a
// round-robin grant; converts MSB-first, one bit per cycle.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | waiting for a request; grant drives the ready of the winner
//   ST_CONV | producing one binary bit per cycle, idx counting down to 0
//   ST_DONE | result presented on out_valid until the consumer takes it
module gray_conv_sched
  import gray_conv_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_gray,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_gray,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_bin,
  output logic             out_src,
  input  logic             out_ready,
  output logic             busy
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

  state_e             state_q;
  logic               rr_q;
  logic [WIDTH-1:0]   gray_q;
  logic [WIDTH-1:0]   bin_q;
  logic [IDX_W-1:0]   idx_q;
  logic               acc_q;
  logic [SRC_W-1:0]   src_q;
  logic [1:0]         grant;
  logic               conv_bit_d;

  gray_rr_arb2 u_arb (
    .valid_i (req1_valid ? {1'b1, req0_valid} : {1'b0, req0_valid}),
    .rr_i    (rr_q),
    .grant_o (grant)
  );

  // Readies are held low while reset is asserted, whatever the inputs do.
  assign req0_ready = rst_n & (state_q == ST_IDLE) & grant[0];
  assign req1_ready = rst_n & (state_q == ST_IDLE) & grant[1];

  // acc_q carries the previously produced (more significant) binary bit,
  // cleared at acceptance so the MSB comes out as the Gray MSB itself.
  assign conv_bit_d = acc_q ^ gray_q[idx_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rr_q    <= 1'b0;
      gray_q  <= '0;
      bin_q   <= '0;
      idx_q   <= '0;
      acc_q   <= 1'b0;
      src_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant != 2'b00) begin
            gray_q  <= grant[1] ? req1_gray : req0_gray;
            src_q   <= SRC_W'(grant[1]);
            rr_q    <= grant[0];
            idx_q   <= IDX_MSB;
            acc_q   <= 1'b0;
            state_q <= ST_CONV;
          end
        end
        ST_CONV: begin
          bin_q[idx_q] <= conv_bit_d;
          acc_q        <= conv_bit_d;
          if (idx_q == '0) begin
            state_q <= ST_DONE;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_bin   = bin_q;
  assign out_src   = src_q;

endmodule

// File: tb/tb_gray_conv_sched.sv
// Directed and randomized bench for gray_conv_sched at WIDTH=4 and WIDTH=8,
// checked against a prefix-XOR model and a round-robin grant model.
module tb_gray_conv_sched;

  localparam int W4 = 4;
  localparam int W8 = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic a_v0, a_v1, a_r0, a_r1, a_ov, a_os, a_ordy, a_busy;
  logic [W4-1:0] a_g0, a_g1, a_ob;
  logic b_v0, b_v1, b_r0, b_r1, b_ov, b_os, b_ordy, b_busy;
  logic [W8-1:0] b_g0, b_g1, b_ob;

  int n_chk = 0, n_pass = 0, n_fail = 0, cyc = 0;
  int perm4[16];
  int perm8[256];
  int i0, i1, k, gcnt, last_res, j, tmp;
  bit acc0, acc1;
  bit hold0, hold1, busy_m, acc_pend, hs_pend, prio;
  int acc_cyc, acc_src, e_src, e_bin;
  logic [W4-1:0] rg0, rg1;
  logic [1:0] exp_gnt;
  int exp_src_q[$];
  int exp_bin_q[$];

  gray_conv_sched #(.WIDTH(W4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(a_v0), .req0_gray(a_g0), .req0_ready(a_r0),
    .req1_valid(a_v1), .req1_gray(a_g1), .req1_ready(a_r1),
    .out_valid(a_ov), .out_bin(a_ob), .out_src(a_os),
    .out_ready(a_ordy), .busy(a_busy)
  );

  gray_conv_sched #(.WIDTH(W8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(b_v0), .req0_gray(b_g0), .req0_ready(b_r0),
    .req1_valid(b_v1), .req1_gray(b_g1), .req1_ready(b_r1),
    .out_valid(b_ov), .out_bin(b_ob), .out_src(b_os),
    .out_ready(b_ordy), .busy(b_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Binary value of a Gray word: XOR of the word with all its right shifts.
  function automatic int ref_bin(input int g, input int w);
    int b;
    b = 0;
    for (int s = 0; s < w; s++) b = b ^ (g >> s);
    return b & ((1 << w) - 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    cyc++;
    #1;
  endtask

  task automatic wait_out4(input string tag);
    int n;
    n = 0;
    while (a_ov !== 1'b1 && n < 40) begin
      nxt();
      n++;
    end
    check({tag, "_out_valid"}, 32'(a_ov), 32'd1);
  endtask

  initial begin
    a_v0 = 0; a_v1 = 0; a_g0 = '0; a_g1 = '0; a_ordy = 1;
    b_v0 = 0; b_v1 = 0; b_g0 = '0; b_g1 = '0; b_ordy = 1;

    // Reset held with random inputs
    rst_n = 0;
    for (int c = 0; c < 5; c++) begin
      nxt();
      a_v0 = 1'($urandom); a_v1 = 1'($urandom); a_g0 = 4'($urandom); a_g1 = 4'($urandom);
      a_ordy = 1'($urandom);
      #1;
      check("rst_ov", 32'(a_ov), 0);
      check("rst_bin", 32'(a_ob), 0);
      check("rst_src", 32'(a_os), 0);
      check("rst_busy", 32'(a_busy), 0);
      check("rst_ready", 32'({a_r1, a_r0}), 0);
      check("rst8_ov_busy", 32'({b_ov, b_busy}), 0);
    end
    a_v0 = 0; a_v1 = 0; a_ordy = 1;
    nxt();
    rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      nxt();
      check("idle_ready", 32'({a_r1, a_r0}), 0);
      check("idle_busy", 32'(a_busy), 0);
    end

    // Single request: latency and busy window
    a_v0 = 1; a_g0 = 4'b0110;
    #1;
    check("single_ready", 32'({a_r1, a_r0}), 32'b01);
    @(posedge clk);
    for (int c = 1; c <= W4; c++) begin
      nxt();
      a_v0 = 0;
      check("single_busy", 32'(a_busy), 1);
      check("single_early_ov", 32'(a_ov), 0);
    end
    nxt();
    check("single_ov", 32'(a_ov), 1);
    check("single_bin", 32'(a_ob), 32'(ref_bin(4'b0110, W4)));
    check("single_src", 32'(a_os), 0);
    check("single_busy_done", 32'(a_busy), 1);
    nxt();
    check("single_ov_fall", 32'(a_ov), 0);
    check("single_idle", 32'(a_busy), 0);

    // Simultaneous requests after a fresh reset: req0 first
    rst_n = 0;
    nxt();
    rst_n = 1;
    a_v0 = 1; a_g0 = 4'b1000; a_v1 = 1; a_g1 = 4'b1101;
    #1;
    check("sim_first_grant", 32'({a_r1, a_r0}), 32'b01);
    @(posedge clk);
    nxt();
    a_v0 = 0;
    wait_out4("sim0");
    check("sim0_bin", 32'(a_ob), 32'(ref_bin(4'b1000, W4)));
    check("sim0_src", 32'(a_os), 0);
    nxt();
    check("sim_second_grant", 32'({a_r1, a_r0}), 32'b10);
    @(posedge clk);
    nxt();
    a_v1 = 0;
    wait_out4("sim1");
    check("sim1_bin", 32'(a_ob), 32'(ref_bin(4'b1101, W4)));
    check("sim1_src", 32'(a_os), 1);
    nxt();

    // Backpressure in DONE
    a_ordy = 0; a_v1 = 1; a_g1 = 4'b0011;
    #1;
    check("bp_grant", 32'({a_r1, a_r0}), 32'b10);
    @(posedge clk);
    nxt();
    a_v1 = 0;
    wait_out4("bp");
    for (int c = 0; c < 10; c++) begin
      a_v0 = 1; a_v1 = 1;
      #1;
      check("bp_ov", 32'(a_ov), 1);
      check("bp_bin", 32'(a_ob), 32'(ref_bin(4'b0011, W4)));
      check("bp_src", 32'(a_os), 1);
      check("bp_ready", 32'({a_r1, a_r0}), 0);
      nxt();
    end
    a_v0 = 0; a_v1 = 0; a_ordy = 1;
    @(posedge clk);
    nxt();
    check("bp_release_ov", 32'(a_ov), 0);
    check("bp_release_busy", 32'(a_busy), 0);

    // Reset two cycles into CONV, after a req0 grant moved priority to req1
    a_v0 = 1; a_g0 = 4'b1010;
    #1;
    check("rmid_grant", 32'({a_r1, a_r0}), 32'b01);
    @(posedge clk);
    nxt();
    a_v0 = 0;
    nxt();
    check("rmid_busy", 32'(a_busy), 1);
    check("rmid_msb", 32'(a_ob[3]), 1);
    rst_n = 0;
    #1;
    check("rmid_async_ov", 32'(a_ov), 0);
    check("rmid_async_bin", 32'(a_ob), 0);
    check("rmid_async_src", 32'(a_os), 0);
    check("rmid_async_busy", 32'(a_busy), 0);
    nxt();
    rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      nxt();
      check("rmid_no_stale", 32'({a_ov, a_busy}), 0);
    end
    a_v0 = 1; a_g0 = 4'b0001; a_v1 = 1; a_g1 = 4'b0111;
    #1;
    check("rmid_prio", 32'({a_r1, a_r0}), 32'b01);
    @(posedge clk);
    nxt();
    a_v0 = 0;
    wait_out4("rmid0");
    check("rmid0_bin", 32'(a_ob), 32'(ref_bin(4'b0001, W4)));
    nxt();
    check("rmid_second_grant", 32'({a_r1, a_r0}), 32'b10);
    @(posedge clk);
    nxt();
    a_v1 = 0;
    wait_out4("rmid1");
    check("rmid1_bin", 32'(a_ob), 32'(ref_bin(4'b0111, W4)));
    check("rmid1_src", 32'(a_os), 1);
    nxt();

    // Exhaustive WIDTH=4 sweep with both requesters continuously valid
    for (int i = 0; i < 16; i++) perm4[i] = i;
    for (int i = 15; i > 0; i--) begin
      j = int'($urandom_range(i, 0)); tmp = perm4[i]; perm4[i] = perm4[j]; perm4[j] = tmp;
    end
    i0 = 0; i1 = 0; k = 0; gcnt = 0; acc0 = 0; acc1 = 0; last_res = 0;
    for (int c = 0; c < 400 && k < 16; c++) begin
      nxt();
      if (acc0) i0++;
      if (acc1) i1++;
      if (a_ov === 1'b1) begin
        check("sw4_src", 32'(a_os), 32'(k % 2));
        check("sw4_bin", 32'(a_ob), 32'(ref_bin(perm4[k], W4)));
        if (k > 0) check("sw4_period", 32'(cyc - last_res), 32'(W4 + 2));
        last_res = cyc;
        k++;
      end
      a_v0 = (i0 < 8); a_g0 = (i0 < 8) ? 4'(perm4[2*i0]) : 4'h0;
      a_v1 = (i1 < 8); a_g1 = (i1 < 8) ? 4'(perm4[2*i1+1]) : 4'h0;
      #1;
      acc0 = a_v0 & a_r0;
      acc1 = a_v1 & a_r1;
      if (acc0 | acc1) begin
        check("sw4_alternate", 32'(acc1), 32'(gcnt % 2));
        gcnt++;
      end
    end
    check("sw4_count", 32'(k), 32'd16);

    // Random traffic with random backpressure
    hold0 = 0; hold1 = 0; busy_m = 0; acc_pend = 0; hs_pend = 0; prio = 0;
    rg0 = '0; rg1 = '0;
    for (int c = 0; c < 400; c++) begin
      nxt();
      if (acc_pend) begin
        busy_m = 1; acc_cyc = cyc - 1; acc_pend = 0;
        if (acc_src == 0) hold0 = 0; else hold1 = 0;
      end
      if (hs_pend) begin
        busy_m = 0; hs_pend = 0;
      end
      check("rnd_busy", 32'(a_busy), 32'(busy_m));
      if (busy_m) check("rnd_latency", 32'(a_ov), 32'(cyc - acc_cyc >= W4 + 1));
      a_ordy = ($urandom_range(3, 0) != 0);
      if (busy_m && a_ov === 1'b1 && a_ordy && exp_src_q.size() > 0) begin
        e_src = exp_src_q.pop_front();
        e_bin = exp_bin_q.pop_front();
        check("rnd_src", 32'(a_os), 32'(e_src));
        check("rnd_bin", 32'(a_ob), 32'(e_bin));
        hs_pend = 1;
      end
      if (!hold0 && $urandom_range(2, 0) == 0) begin hold0 = 1; rg0 = 4'($urandom); end
      if (!hold1 && $urandom_range(2, 0) == 0) begin hold1 = 1; rg1 = 4'($urandom); end
      a_v0 = hold0; a_g0 = rg0; a_v1 = hold1; a_g1 = rg1;
      #1;
      if (busy_m) begin
        check("rnd_ready_busy", 32'({a_r1, a_r0}), 0);
      end else begin
        if (hold0 && hold1) exp_gnt = prio ? 2'b10 : 2'b01;
        else exp_gnt = {hold1, hold0};
        check("rnd_grant", 32'({a_r1, a_r0}), 32'(exp_gnt));
        if (exp_gnt != 2'b00) begin
          acc_pend = 1;
          acc_src = exp_gnt[1] ? 1 : 0;
          prio = (acc_src == 0);
          exp_src_q.push_back(acc_src);
          exp_bin_q.push_back(ref_bin(acc_src == 1 ? int'(rg1) : int'(rg0), W4));
        end
      end
    end
    a_v0 = 0; a_v1 = 0; a_ordy = 1;

    // Exhaustive WIDTH=8 sweep with both requesters continuously valid
    for (int i = 0; i < 256; i++) perm8[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = int'($urandom_range(i, 0)); tmp = perm8[i]; perm8[i] = perm8[j]; perm8[j] = tmp;
    end
    i0 = 0; i1 = 0; k = 0; gcnt = 0; acc0 = 0; acc1 = 0; last_res = 0;
    for (int c = 0; c < 4000 && k < 256; c++) begin
      nxt();
      if (acc0) i0++;
      if (acc1) i1++;
      if (b_ov === 1'b1) begin
        check("sw8_src", 32'(b_os), 32'(k % 2));
        check("sw8_bin", 32'(b_ob), 32'(ref_bin(perm8[k], W8)));
        if (k > 0) check("sw8_period", 32'(cyc - last_res), 32'(W8 + 2));
        last_res = cyc;
        k++;
      end
      b_v0 = (i0 < 128); b_g0 = (i0 < 128) ? 8'(perm8[2*i0]) : 8'h0;
      b_v1 = (i1 < 128); b_g1 = (i1 < 128) ? 8'(perm8[2*i1+1]) : 8'h0;
      #1;
      acc0 = b_v0 & b_r0;
      acc1 = b_v1 & b_r1;
      if (acc0 | acc1) begin
        check("sw8_alternate", 32'(acc1), 32'(gcnt % 2));
        gcnt++;
      end
    end
    check("sw8_count", 32'(k), 32'd256);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gray_conv_sched.md
Name: gray_conv_sched

Overview:
Shares one bit-serial Gray-to-binary conversion datapath between two requesters, such as two encoder or pointer channels, using a round-robin grant. Each requester supplies a WIDTH-bit Gray word over a valid/ready handshake. The block converts the word MSB-first, one bit per cycle, and presents the binary result with the source ID on an output valid/ready handshake. It sits between the Gray-coded sources and the binary consumers.

Parameters:
WIDTH, 4, Gray/binary word width; legal range WIDTH >= 2.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  reset; asynchronous, active-low
req0_valid  input  1  requester 0 has a Gray word
req0_gray  input  WIDTH  requester 0 Gray word
req0_ready  output  1  requester 0 word accepted this cycle
req1_valid  input  1  requester 1 has a Gray word
req1_gray  input  WIDTH  requester 1 Gray word
req1_ready  output  1  requester 1 word accepted this cycle
out_valid  output  1  conversion result available
out_bin  output  WIDTH  binary result
out_src  output  1  requester ID of the result (0/1)
out_ready  input  1  consumer accepts the result
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr priority pointer=0 (req0 favoured).
  - out_valid=0, out_bin=0, out_src=0, busy=0.
  - Shift/index registers cleared.
  - Any in-flight conversion is discarded with no result produced.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - reqN_ready is combinational and equals grantN.
  - grant goes to the only valid requester. If both are valid, it goes to the requester selected by rr.
  - A transfer occurs on reqN_valid && reqN_ready. On that edge: capture the Gray word and the source ID, set idx=WIDTH-1, set rr to the other requester, go to CONV.
  - No valid input: stay in IDLE, both ready signals stay 0.
- CONV:
  - One result bit per cycle:
    - at idx=WIDTH-1: bin[idx]=g[idx]
    - otherwise: bin[idx]=bin[idx+1]^g[idx]
  - idx decrements each cycle; when idx=0 the bit is written and the state moves to DONE.
  - The idx counter is $clog2(WIDTH) bits wide and never wraps below 0.
  - Both ready signals are 0 in this state.
- DONE:
  - out_valid=1; out_bin and out_src are registered and held stable until out_ready=1.
  - On out_valid && out_ready, go to IDLE; out_valid falls the next cycle.
  - The next acceptance can occur at the earliest in the first IDLE cycle.
- Latency and throughput:
  - Word accepted at edge T gives out_valid=1 in cycle T+WIDTH+1.
  - Throughput is 1 word per WIDTH+2 cycles, with out_ready tied high.
- Input handshake rules:
  - Requesters hold valid and data stable until ready; the block does not check this.
  - A requester whose valid drops before grant loses nothing.
- Fairness: with both requesters continuously valid, grants strictly alternate.
- out_bin is not cleared on leaving DONE; it keeps the last result until the next conversion overwrites it bit by bit. Consumers sample it only when out_valid=1.

Decomposition:
- Package gray_conv_pkg:
  - state enum type (IDLE/CONV/DONE)
  - SRC_W=1 constant
  - reference function gray_to_bin(g) for benches and assertions
- One sub-module, gray_rr_arb2: 2-way round-robin arbiter with inputs valid[1:0], rr and output grant[1:0], purely combinational. rr stays in the parent so it updates only on an accepted transfer.

Test Plan:
- Reset check: hold rst_n=0 with random inputs -> out_valid=0, out_bin=0, out_src=0, busy=0, req0_ready=req1_ready=0. Release with no valid input -> stays IDLE, both ready signals 0.
- Single request: req0 gray 4'b0110 accepted at edge T, out_ready=1 -> out_valid=1 at T+5 with out_bin=4'b0100, out_src=0. busy=1 from T+1 through the DONE cycle.
- Simultaneous requests after reset: req0=4'b1000, req1=4'b1101 -> req0 granted first giving out_bin=4'b1111, src=0. Then req1 is granted in the next IDLE cycle giving out_bin=4'b1001, src=1.
- Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid stays 1, out_bin and out_src stable, both ready signals 0. Raising out_ready gives one handshake and return to IDLE.
- Reset mid-operation: assert rst_n=0 two cycles into CONV -> outputs zero immediately without waiting for a clock edge. After release, no stale out_valid appears and req0 has priority.
- Exhaustive and fairness: all 16 Gray codes with both valid held high -> grants alternate 0,1,0,1. Every out_bin equals gray_to_bin(input), where bin[i] is the XOR-reduction of g[W-1:i]. Repeat the sweep with WIDTH=8, 256 codes.
